shift_seq_ctrl: RTL and testbench

Sequencer for the 8-bit bidirectional serial shift register datapath. It accepts a parallel word with a direction and a bit count over a start/busy/done handshake. It then drives the shifter's serial input (`si`), direction (`lr`) and a per-cycle shift qualifier (`shift_en`) for exactly that many clocks. At the same time it captures the bit returned from the shifter's far end (`so_in`) into a parallel result word.

---
 rtl/shift_seq_ctrl_if.sv | 28 ++
 rtl/shift_seq_ctrl.sv | 100 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_ctrl_if.sv
// Bundle of signals between shift_seq_ctrl, its requester and the attached shift register.
// master = requester/shifter side, slave = sequencer side.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
);
  logic             start;
  logic             dir;
  logic [WIDTH-1:0] din;
  logic [CW-1:0]    len;
  logic             so_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             si;
  logic             lr;
  logic             shift_en;

  modport master (
    output start, dir, din, len, so_in,
    input  busy, done, dout, si, lr, shift_en
  );

  modport slave (
    input  start, dir, din, len, so_in,
    output busy, done, dout, si, lr, shift_en
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer for an external bidirectional shift register: serializes a word on si while
// capturing the bits returned on so_in, over a start/busy/done handshake.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  shift_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    len_clamped;
  logic             lr_q, lr_d;

  function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] l);
    if (l > CW'(WIDTH)) return CW'(WIDTH);
    return l;
  endfunction

  assign len_clamped = clamp_len(bus.len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      lr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      lr_q    <= lr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    lr_d    = lr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_d  = bus.din;
          lr_d  = bus.dir;
          cnt_d = len_clamped;
          if (len_clamped == '0) begin
            state_d = DONE;
            dout_d  = rx_q;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        // so_in is the bit leaving the shifter on this same edge
        if (lr_q) begin
          tx_d = tx_q >> 1;
          rx_d = {bus.so_in, rx_q[WIDTH-1:1]};
        end else begin
          tx_d = tx_q << 1;
          rx_d = {rx_q[WIDTH-2:0], bus.so_in};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          dout_d  = rx_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs come from registers so si is stable for a full cycle before the shift edge
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.shift_en = (state_q == SHIFT);
  assign bus.si       = (state_q == SHIFT) ? (lr_q ? tx_q[0] : tx_q[WIDTH-1]) : 1'b0;
  assign bus.lr       = lr_q;
  assign bus.dout     = dout_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: scoreboard of expected si bits and dout words, with an
// external shifter model for loopback, plus per-scenario timing and count checks.
module tb_shift_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  shift_seq_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  bit         exp_si_q[$];
  logic [7:0] exp_dout_q[$];
  int         se_cnt;
  int         done_cnt;
  bit         e_si;
  logic [7:0] e_dout;

  // so_in source: 0 = constant, 1 = si looped back, 2 = external shifter model
  int         so_mode = 0;
  logic       so_const = 1'b0;
  logic       sh_clr = 1'b0;
  logic [7:0] sh_q = 8'h00;

  always_comb begin
    case (so_mode)
      0:       bus.so_in = so_const;
      1:       bus.so_in = bus.si;
      default: bus.so_in = bus.lr ? sh_q[0] : sh_q[7];
    endcase
  end

  always @(posedge clk) begin
    if (sh_clr)            sh_q <= 8'h00;
    else if (bus.shift_en) sh_q <= bus.lr ? {bus.si, sh_q[7:1]} : {sh_q[6:0], bus.si};
  end

  // Scoreboard consumer: one si bit per shift cycle, one dout word per done pulse
  always @(negedge clk) begin
    if (bus.shift_en === 1'b1) begin
      se_cnt++;
      checks++;
      if (exp_si_q.size() == 0) begin
        errors++;
        $display("FAIL si_extra: shift_en high with si=%0b, required no shift cycle", bus.si);
      end else begin
        e_si = exp_si_q.pop_front();
        if (bus.si !== e_si) begin
          errors++;
          $display("FAIL si_bit: got %0b, required %0b (t=%0t)", bus.si, e_si, $time);
        end
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      checks++;
      if (exp_dout_q.size() == 0) begin
        errors++;
        $display("FAIL done_extra: done with dout=%h, required no done", bus.dout);
      end else begin
        e_dout = exp_dout_q.pop_front();
        if (bus.dout !== e_dout) begin
          errors++;
          $display("FAIL dout: got %h, required %h (t=%0t)", bus.dout, e_dout, $time);
        end
      end
    end
  end

  task automatic push_bits(input logic [7:0] w, input int n, input bit msb_first);
    for (int i = 0; i < n; i++) exp_si_q.push_back(msb_first ? w[7-i] : w[i]);
  endtask

  task automatic launch(input logic d, input logic [7:0] w, input logic [3:0] l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir   = d;
    bus.din   = w;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy !== 1'b0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    bus.din   = '0;
    bus.len   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.si, bus.shift_en, bus.lr, bus.dout} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b si=%b se=%b lr=%b dout=%h, required all 0",
               bus.busy, bus.done, bus.si, bus.shift_en, bus.lr, bus.dout);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_left_ones();
    int cyc;
    bit lr_bad;
    so_mode = 0; so_const = 1'b1;
    se_cnt = 0; done_cnt = 0; lr_bad = 1'b0;
    push_bits(8'hA5, 8, 1'b1);
    exp_dout_q.push_back(8'hFF);
    launch(1'b0, 8'hA5, 4'd8);
    cyc = 0;
    while (bus.busy !== 1'b0 && cyc < 100) begin
      if (bus.lr !== 1'b0) lr_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 100) begin errors++; $display("FAIL left_timeout: busy stuck after %0d cycles, required idle", cyc); end
    checks++;
    if (se_cnt !== 8) begin errors++; $display("FAIL left_shift_cnt: got %0d, required 8", se_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL left_done_cnt: got %0d, required 1", done_cnt); end
    checks++;
    if (lr_bad) begin errors++; $display("FAIL left_lr: lr went 1 during transfer, required 0"); end
  endtask

  task automatic test_right_loop();
    int cyc;
    so_mode = 1;
    se_cnt = 0; done_cnt = 0;
    push_bits(8'hA5, 8, 1'b0);
    exp_dout_q.push_back(8'hA5);
    launch(1'b1, 8'hA5, 4'd8);
    wait_idle(cyc);
    checks++;
    if (cyc >= 100) begin errors++; $display("FAIL right_timeout: busy stuck after %0d cycles, required idle", cyc); end
    checks++;
    if (se_cnt !== 8) begin errors++; $display("FAIL right_shift_cnt: got %0d, required 8", se_cnt); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.lr !== 1'b1 || bus.dout !== 8'hA5) begin
      errors++;
      $display("FAIL right_hold: lr=%b dout=%h, required lr=1 dout=a5", bus.lr, bus.dout);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int idle_at;
    int second_at;
    so_mode = 2;
    sh_clr = 1'b1;
    @(negedge clk);
    sh_clr = 1'b0;
    se_cnt = 0; done_cnt = 0;
    push_bits(8'h3C, 8, 1'b1);
    push_bits(8'hC3, 8, 1'b1);
    exp_dout_q.push_back(8'h00);
    exp_dout_q.push_back(8'h3C);
    @(negedge clk);
    bus.start = 1'b1; bus.dir = 1'b0; bus.din = 8'h3C; bus.len = 4'd8;
    @(negedge clk);
    bus.din = 8'hC3;
    k = 0; idle_at = -1; second_at = -1;
    while (k < 60 && !(second_at >= 0 && bus.busy === 1'b0)) begin
      if (bus.busy === 1'b0 && idle_at < 0) idle_at = k;
      if (idle_at >= 0 && second_at < 0 && bus.shift_en === 1'b1) begin
        second_at = k;
        bus.start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    checks++;
    if (idle_at !== 9) begin errors++; $display("FAIL b2b_idle_gap: idle at sample %0d, required 9", idle_at); end
    checks++;
    if (second_at !== 10) begin errors++; $display("FAIL b2b_restart: second shift at sample %0d, required 10", second_at); end
    checks++;
    if (se_cnt !== 16 || done_cnt !== 2) begin
      errors++;
      $display("FAIL b2b_counts: shifts=%0d dones=%0d, required 16 and 2", se_cnt, done_cnt);
    end
    checks++;
    if (bus.dout !== 8'h3C) begin errors++; $display("FAIL b2b_dout: got %h, required 3c", bus.dout); end
  endtask

  task automatic test_len_zero();
    int cyc;
    so_mode = 0; so_const = 1'b1;
    se_cnt = 0; done_cnt = 0;
    exp_dout_q.push_back(8'h3C);
    launch(1'b0, 8'hFF, 4'd0);
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL len0_done: done=%b the cycle after start, required 1", bus.done); end
    wait_idle(cyc);
    checks++;
    if (se_cnt !== 0 || done_cnt !== 1 || cyc !== 1) begin
      errors++;
      $display("FAIL len0_counts: shifts=%0d dones=%0d wait=%0d, required 0 1 1", se_cnt, done_cnt, cyc);
    end
  endtask

  task automatic test_len_clamp();
    int cyc;
    so_mode = 0; so_const = 1'b0;
    se_cnt = 0; done_cnt = 0;
    push_bits(8'hF0, 8, 1'b1);
    exp_dout_q.push_back(8'h00);
    launch(1'b0, 8'hF0, 4'd15);
    wait_idle(cyc);
    checks++;
    if (se_cnt !== 8 || done_cnt !== 1) begin
      errors++;
      $display("FAIL len15_clamp: shifts=%0d dones=%0d, required 8 and 1", se_cnt, done_cnt);
    end
  endtask

  task automatic test_len3_right();
    int cyc;
    so_mode = 0; so_const = 1'b1;
    se_cnt = 0; done_cnt = 0;
    push_bits(8'h06, 3, 1'b0);
    exp_dout_q.push_back(8'hE0);
    launch(1'b1, 8'h06, 4'd3);
    wait_idle(cyc);
    checks++;
    if (se_cnt !== 3 || bus.dout !== 8'hE0) begin
      errors++;
      $display("FAIL len3_right: shifts=%0d dout=%h, required 3 and e0", se_cnt, bus.dout);
    end
  endtask

  task automatic test_start_ignored();
    int k;
    so_mode = 0; so_const = 1'b1;
    se_cnt = 0; done_cnt = 0;
    push_bits(8'h81, 5, 1'b1);
    exp_dout_q.push_back(8'h1F);
    launch(1'b0, 8'h81, 4'd5);
    bus.dir = 1'b1; bus.len = 4'd8; bus.din = 8'hFF;
    for (k = 0; k < 40; k++) begin
      if (k == 2 || k == 5) bus.start = 1'b1;
      if (k == 3 || k == 6) bus.start = 1'b0;
      if (bus.busy === 1'b0) break;
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++;
    if (k !== 6) begin errors++; $display("FAIL ign_occupancy: idle at sample %0d, required 6", k); end
    repeat (3) @(negedge clk);
    checks++;
    if (se_cnt !== 5 || done_cnt !== 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_counts: shifts=%0d dones=%0d busy=%b, required 5 1 0", se_cnt, done_cnt, bus.busy);
    end
    bus.dir = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    so_mode = 0; so_const = 1'b1;
    se_cnt = 0; done_cnt = 0;
    push_bits(8'hA5, 4, 1'b1);
    launch(1'b1, 8'hA5, 4'd8);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.si, bus.shift_en, bus.lr, bus.dout} !== 13'd0) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%b done=%b si=%b se=%b lr=%b dout=%h, required all 0",
               bus.busy, bus.done, bus.si, bus.shift_en, bus.lr, bus.dout);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (se_cnt !== 4 || done_cnt !== 0) begin
      errors++;
      $display("FAIL midrst_abort: shifts=%0d dones=%0d, required 4 and 0", se_cnt, done_cnt);
    end
    so_mode = 1;
    se_cnt = 0; done_cnt = 0;
    push_bits(8'h5A, 8, 1'b0);
    exp_dout_q.push_back(8'h5A);
    launch(1'b1, 8'h5A, 4'd8);
    wait_idle(cyc);
    checks++;
    if (se_cnt !== 8 || done_cnt !== 1 || bus.dout !== 8'h5A) begin
      errors++;
      $display("FAIL midrst_recover: shifts=%0d dones=%0d dout=%h, required 8 1 5a", se_cnt, done_cnt, bus.dout);
    end
  endtask

  initial begin
    test_reset();
    test_left_ones();
    test_right_loop();
    test_back_to_back();
    test_len_zero();
    test_len_clamp();
    test_len3_right();
    test_start_ignored();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_si_q.size() != 0 || exp_dout_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d si bits and %0d words left, required 0 and 0",
               exp_si_q.size(), exp_dout_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
